// File: rtl/calc1_port_monitor_if.sv
// Command/response pin bundle observed by one calc1 port monitor.
// The bench or the DUV side drives it as master; the monitor listens as slave.
interface calc1_port_monitor_if;
   logic [3:0]  req_cmd;
   logic [31:0] req_data;
   logic [1:0]  out_resp;
   logic [31:0] out_data;

   modport master (output req_cmd, req_data, out_resp, out_data);
   modport slave  (input  req_cmd, req_data, out_resp, out_data);
endinterface

// File: rtl/calc1_port_monitor.sv
// Per-port calc1 transaction monitor: queues commands in order, pairs each response
// with its oldest outstanding command and flags unexpected, overflow and timeout errors.
module calc1_port_monitor #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64,
   parameter int SEQW    = 8
) (
   input  logic                     c_clk,
   input  logic                     reset,
   calc1_port_monitor_if.slave      port,
   output logic                     mon_valid,
   output logic [3:0]               mon_cmd,
   output logic [SEQW-1:0]          mon_seq,
   output logic [1:0]               mon_resp,
   output logic [31:0]              mon_data,
   output logic [31:0]              mon_op1,
   output logic                     err_unexp,
   output logic                     err_ovf,
   output logic                     err_timeout,
   output logic [$clog2(DEPTH):0]   outstanding
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t          state, state_nxt;
   logic [3:0]      mem_cmd  [DEPTH];
   logic [31:0]     mem_op1  [DEPTH];
   logic [SEQW-1:0] mem_seq  [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr, pop_idx;
   logic [CW-1:0]   count, count_nxt, avail;
   logic [TW-1:0]   tcnt;
   logic [SEQW-1:0] seq;
   logic            is_drop, pop, push, unexp, ovf, tmo_hit;

   // In DROP the head is discarded this edge, so a response pairs with the entry behind it.
   always_comb begin
      is_drop   = (state == DROP);
      avail     = count - CW'(is_drop);
      pop       = (|port.out_resp) && (avail != '0);
      unexp     = (|port.out_resp) && (avail == '0);
      push      = (|port.req_cmd) && ((count != CW'(DEPTH)) || pop || is_drop);
      ovf       = (|port.req_cmd) && !push;
      pop_idx   = rd_ptr + AW'(is_drop);
      count_nxt = count + CW'(push) - CW'(pop) - CW'(is_drop);
      tmo_hit   = (state == WAIT) && !pop && (tcnt == TW'(TIMEOUT - 1));
      state_nxt = state;
      case (state)
         IDLE:    if (push) state_nxt = WAIT;
         WAIT:    if (count_nxt == '0) state_nxt = IDLE;
                  else if (tmo_hit)     state_nxt = DROP;
         DROP:    state_nxt = (count_nxt != '0) ? WAIT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Storage needs no reset: validity is tracked entirely by the pointers and count.
   always_ff @(posedge c_clk) begin
      if (push) begin
         mem_cmd[wr_ptr] <= port.req_cmd;
         mem_op1[wr_ptr] <= port.req_data;
         mem_seq[wr_ptr] <= seq;
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         tcnt        <= '0;
         seq         <= '0;
         mon_valid   <= 1'b0;
         mon_cmd     <= '0;
         mon_seq     <= '0;
         mon_resp    <= '0;
         mon_data    <= '0;
         mon_op1     <= '0;
         err_unexp   <= 1'b0;
         err_ovf     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            seq    <= seq + SEQW'(1);
         end
         rd_ptr <= rd_ptr + AW'(is_drop) + AW'(pop);
         count  <= count_nxt;
         if (pop || is_drop || (push && count == '0))
            tcnt <= '0;
         else if (state == WAIT && tcnt != TW'(TIMEOUT - 1))
            tcnt <= tcnt + TW'(1);
         mon_valid <= pop;
         if (pop) begin
            mon_cmd  <= mem_cmd[pop_idx];
            mon_seq  <= mem_seq[pop_idx];
            mon_op1  <= mem_op1[pop_idx];
            mon_resp <= port.out_resp;
            mon_data <= port.out_data;
         end
         err_unexp   <= unexp;
         err_ovf     <= ovf;
         err_timeout <= tmo_hit;
      end
   end

   assign outstanding = count;

endmodule
